gate_tt_checker: RTL and testbench

- Hardware truth-table checker for any 2-input combinational gate under test (DUT); the in-silicon counterpart of a gate testbench.
- Drives the four input vectors to the DUT and waits a programmable settle time after each one.
- Samples the DUT output for each vector, builds the observed 4-bit truth table and compares it against an expected table.
- Used for on-chip self-test of gate cells; results are read by the system controller.

---
 rtl/gate_tt_checker.sv | 140 ++++++++++++++
 tb/tb_gate_tt_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   On-chip truth-table checker for a 2-input combinational gate. A run walks
//   the four input vectors {a,b} = 00, 01, 10, 11, holds each one for
//   SETTLE_CYCLES+1 clock cycles, samples dut_y on the last edge of each hold,
//   and compares the collected 4-bit table against EXPECT.
//
//   Parameters
//     SETTLE_CYCLES : extra cycles each vector is held before sampling (0..255)
//     EXPECT        : expected table, bit i = expected y for {a,b} = i
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset (priority over start)
//     start      in   one-cycle run request, honoured only while busy = 0
//     dut_y      in   gate output, assumed synchronous to clk
//     dut_a      out  gate input a (vector index bit 1)
//     dut_b      out  gate input b (vector index bit 0)
//     busy       out  high from the accepted start through the done cycle
//     done       out  one-cycle pulse when the results are valid
//     pass       out  result_tt == EXPECT, held until the next start
//     result_tt  out  observed table, bit i = sampled dut_y for vector i
//     fail_mask  out  result_tt ^ EXPECT, held until the next start
//     fail_count out  (TT_CHK_ERRCNT_EN only) saturating count of failed runs
//
//   Optional feature macro: TT_CHK_ERRCNT_EN adds the fail_count output.
//
//   Handshake: start is a single-cycle request sampled only in IDLE; once
//   accepted, busy stays high until the cycle after the done pulse, and every
//   start seen while busy is high is dropped.
module gate_tt_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result_tt,
  output logic [3:0] fail_mask
`ifdef TT_CHK_ERRCNT_EN
  ,
  output logic [7:0] fail_count
`endif
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  // Table as it will look once the current vector's sample is written; used
  // so pass/fail_mask are already valid in the done cycle.
  logic [3:0] tt_next;

  always_comb begin
    tt_next      = result_tt;
    tt_next[idx] = dut_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      result_tt <= 4'b0000;
      fail_mask <= 4'b0000;
`ifdef TT_CHK_ERRCNT_EN
      fail_count <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= HOLD;
            idx       <= 2'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            result_tt <= 4'b0000;
            fail_mask <= 4'b0000;
            cnt       <= CNT_LOAD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Last cycle of this vector: capture the gate output now.
            result_tt <= tt_next;
            cnt       <= CNT_LOAD;
            if (idx != 2'd3) begin
              idx            <= idx + 2'd1;
              {dut_a, dut_b} <= idx + 2'd1;
            end else begin
              state          <= DONE;
              done           <= 1'b1;
              idx            <= 2'd0;
              {dut_a, dut_b} <= 2'b00;
              fail_mask      <= tt_next ^ EXPECT;
              pass           <= (tt_next == EXPECT);
`ifdef TT_CHK_ERRCNT_EN
              if ((tt_next != EXPECT) && (fail_count != 8'hFF))
                fail_count <= fail_count + 8'd1;
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker. Two instances: dut 0 uses the defaults
// (SETTLE_CYCLES=2, EXPECT=NOR) and dut 1 uses SETTLE_CYCLES=0, EXPECT=NAND.
// Each instance drives a behavioural gate described by a 4-bit table.
module tb_gate_tt_checker;

  localparam int         S0   = 2;
  localparam int         S1   = 0;
  localparam logic [3:0] EXP0 = 4'b0001;
  localparam logic [3:0] EXP1 = 4'b0111;

  localparam logic [3:0] G_NOR  = 4'b0001;
  localparam logic [3:0] G_NAND = 4'b0111;
  localparam logic [3:0] G_SA0  = 4'b0000;
  localparam logic [3:0] G_SA1  = 4'b1111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_v  [2];
  logic       dut_y_v  [2];
  logic       dut_a_v  [2];
  logic       dut_b_v  [2];
  logic       busy_v   [2];
  logic       done_v   [2];
  logic       pass_v   [2];
  logic [3:0] result_v [2];
  logic [3:0] fmask_v  [2];
  logic [3:0] gate_v   [2];
`ifdef TT_CHK_ERRCNT_EN
  logic [7:0] fcnt_v   [2];
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural gate: output is the table entry addressed by {a,b}.
  assign dut_y_v[0] = gate_v[0][{dut_a_v[0], dut_b_v[0]}];
  assign dut_y_v[1] = gate_v[1][{dut_a_v[1], dut_b_v[1]}];

  gate_tt_checker #(.SETTLE_CYCLES(S0), .EXPECT(EXP0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_y(dut_y_v[0]),
    .dut_a(dut_a_v[0]), .dut_b(dut_b_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .result_tt(result_v[0]),
    .fail_mask(fmask_v[0])
`ifdef TT_CHK_ERRCNT_EN
    , .fail_count(fcnt_v[0])
`endif
  );

  gate_tt_checker #(.SETTLE_CYCLES(S1), .EXPECT(EXP1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_y(dut_y_v[1]),
    .dut_a(dut_a_v[1]), .dut_b(dut_b_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .result_tt(result_v[1]),
    .fail_mask(fmask_v[1])
`ifdef TT_CHK_ERRCNT_EN
    , .fail_count(fcnt_v[1])
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic gate_eval(input logic [3:0] g, input logic a, input logic b);
    logic [1:0] sel;
    sel = {a, b};
    return g[sel];
  endfunction

  function automatic logic [3:0] model_table(input logic [3:0] g);
    logic [3:0] t;
    logic [1:0] v;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      v    = 2'(i);
      t[i] = gate_eval(g, v[1], v[0]);
    end
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic kick(input int k);
    @(posedge clk); #1;
    start_v[k] = 1'b1;
  endtask

  // Expects start_v[k] already raised by the caller; returns at #1 after
  // edge E0+lat+1 (checker back in IDLE), ready for a back-to-back start.
  task automatic run(input int k, input logic [3:0] g, input int repulse_at, input string name);
    int         s;
    int         lat;
    int         pulses;
    int         done_at;
    logic [3:0] ex;
    logic [3:0] tt;
    logic [1:0] v;
    logic [1:0] exp_q[$];
    s       = (k == 0) ? S0 : S1;
    lat     = 4 * (s + 1);
    ex      = (k == 0) ? EXP0 : EXP1;
    tt      = model_table(g);
    pulses  = 0;
    done_at = -1;
    for (int vi = 0; vi < 4; vi++)
      for (int r = 0; r <= s; r++) exp_q.push_back(2'(vi));
    gate_v[k] = g;

    @(posedge clk); #1;  // edge E0
    start_v[k] = 1'b0;
    total++;
    if (busy_v[k] !== 1'b1) begin
      bad++;
      $display("FAIL %s/dut%0d busy_after_start: got %b want 1", name, k, busy_v[k]);
    end

    for (int j = 0; j <= lat + 1; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      start_v[k] = (j == repulse_at - 1);
      if (done_v[k] === 1'b1) begin
        pulses++;
        done_at = j;
        total += 5;
        if (busy_v[k] !== 1'b1) begin
          bad++;
          $display("FAIL %s/dut%0d busy_in_done: got %b want 1", name, k, busy_v[k]);
        end
        if (result_v[k] !== tt) begin
          bad++;
          $display("FAIL %s/dut%0d result_tt: got %b want %b", name, k, result_v[k], tt);
        end
        if (fmask_v[k] !== (tt ^ ex)) begin
          bad++;
          $display("FAIL %s/dut%0d fail_mask: got %b want %b", name, k, fmask_v[k], tt ^ ex);
        end
        if (pass_v[k] !== (tt == ex)) begin
          bad++;
          $display("FAIL %s/dut%0d pass: got %b want %b", name, k, pass_v[k], tt == ex);
        end
        if ({dut_a_v[k], dut_b_v[k]} !== 2'b00) begin
          bad++;
          $display("FAIL %s/dut%0d ab_in_done: got %b%b want 00", name, k, dut_a_v[k], dut_b_v[k]);
        end
      end
      if (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        total++;
        if ({dut_a_v[k], dut_b_v[k]} !== v) begin
          bad++;
          $display("FAIL %s/dut%0d vector@%0d: got %b%b want %b", name, k, j, dut_a_v[k], dut_b_v[k], v);
        end
      end
    end
    start_v[k] = 1'b0;

    total += 5;
    if (pulses != 1) begin
      bad++;
      $display("FAIL %s/dut%0d done_pulses: got %0d want 1", name, k, pulses);
    end
    if (done_at != lat) begin
      bad++;
      $display("FAIL %s/dut%0d done_latency: got %0d want %0d", name, k, done_at, lat);
    end
    if (busy_v[k] !== 1'b0) begin
      bad++;
      $display("FAIL %s/dut%0d busy_after_done: got %b want 0", name, k, busy_v[k]);
    end
    if (result_v[k] !== tt) begin
      bad++;
      $display("FAIL %s/dut%0d result_held: got %b want %b", name, k, result_v[k], tt);
    end
    if (pass_v[k] !== (tt == ex)) begin
      bad++;
      $display("FAIL %s/dut%0d pass_held: got %b want %b", name, k, pass_v[k], tt == ex);
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_idle_zero(input int k, input string name);
    total++;
    if ({busy_v[k], done_v[k], pass_v[k], dut_a_v[k], dut_b_v[k], result_v[k], fmask_v[k]} !== 13'd0) begin
      bad++;
      $display("FAIL %s/dut%0d outputs: got busy=%b done=%b pass=%b ab=%b%b tt=%b fm=%b want all 0",
               name, k, busy_v[k], done_v[k], pass_v[k], dut_a_v[k], dut_b_v[k], result_v[k], fmask_v[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_idle_zero(k, "reset");
`ifdef TT_CHK_ERRCNT_EN
      total++;
      if (fcnt_v[k] !== 8'd0) begin
        bad++;
        $display("FAIL reset/dut%0d fail_count: got %0d want 0", k, fcnt_v[k]);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_nor();
    kick(0); run(0, G_NOR, -1, "nor_good");
  endtask

  task automatic test_stuck();
    kick(0); run(0, G_SA0, -1, "stuck0");
    kick(0); run(0, G_SA1, -1, "stuck1");
  endtask

  task automatic test_nand_fast();
    kick(1); run(1, G_NAND, -1, "nand_fast");
    kick(1); run(1, G_NOR, -1, "nand_fast_wrong");
  endtask

  task automatic test_restart_ignored();
    kick(0); run(0, G_NOR, 5, "restart_mid");
    kick(0); run(0, G_SA1, 12, "restart_late");
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    gate_v[0] = G_SA1;
    kick(0);
    @(posedge clk); #1;  // edge E0
    start_v[0] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset busy_before: got %b want 1", busy_v[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;  // edge E0+6
    check_idle_zero(0, "mid_reset");
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || busy_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset after_abort: got pulses=%0d busy=%b want 0/0", pulses, busy_v[0]);
    end
    kick(0); run(0, G_NOR, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    kick(0);
    run(0, G_SA0, -1, "b2b_first");
    start_v[0] = 1'b1;  // taken at the first edge back in IDLE
    run(0, G_NOR, -1, "b2b_second");
  endtask

  task automatic test_random();
    logic [3:0] g;
    for (int n = 0; n < 6; n++) begin
      g = 4'($urandom_range(0, 15));
      kick(0); run(0, g, -1, "random");
      g = 4'($urandom_range(0, 15));
      kick(1); run(1, g, -1, "random");
    end
  endtask

`ifdef TT_CHK_ERRCNT_EN
  task automatic test_errcnt();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      kick(0); run(0, G_SA0, -1, "errcnt_bad");
    end
    kick(0); run(0, G_NOR, -1, "errcnt_good");
    total++;
    if (fcnt_v[0] !== 8'd3) begin
      bad++;
      $display("FAIL errcnt count: got %0d want 3", fcnt_v[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (fcnt_v[0] !== 8'd0) begin
      bad++;
      $display("FAIL errcnt cleared: got %0d want 0", fcnt_v[0]);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    gate_v[0]  = G_NOR;
    gate_v[1]  = G_NAND;
    test_reset();
    test_nor();
    test_stuck();
    test_nand_fast();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef TT_CHK_ERRCNT_EN
    test_errcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
